// File: rtl/seg7_pkg.sv
// seg7_pkg: constants shared by the seven-segment driver and the scan decoder.
//   SEG_0..SEG_9, SEG_BLANK : active-low segment patterns, bit6 = a .. bit0 = g
//   CODE_BLANK, CODE_BAD    : digit codes for a blank or an unrecognised pattern
//   ST_SETTLE, ST_LOCKED    : scan decoder FSM state encodings
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_BAD   = 4'hE;

  localparam logic ST_SETTLE = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational seven-segment pattern to digit code.
//   seg  in  7 : active-low pattern, bit6 = a .. bit0 = g
//   code out 4 : 0..9, CODE_BLANK for an all-off pattern, CODE_BAD otherwise
//   ok   out 1 : pattern recognised (digit or blank)
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       ok
);

  always_comb begin
    code = CODE_BAD;
    ok   = 1'b1;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default: begin
        code = CODE_BAD;
        ok   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a multiplexed seven-segment bus and rebuilds the frame.
//   clk         in  1      : system clock
//   rst         in  1      : synchronous active-high reset
//   an          in  NDIG   : digit select, active-low, at most one bit low
//   seg         in  7      : segment pattern, active-low, bit6 = a .. bit0 = g
//   digits      out 4*NDIG : last complete frame, digit i at [4i+3:4i]
//   digit_ok    out NDIG   : per-digit pattern recognised for the published frame
//   frame_valid out 1      : one-cycle pulse when digits/digit_ok update
//   err         out 1      : sticky, more than one an bit seen low
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG   = 8,
  parameter int unsigned STABLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NDIG-1:0]   an,
  input  logic [6:0]        seg,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   digit_ok,
  output logic              frame_valid,
  output logic              err
);

  localparam int unsigned IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [7:0]  STABLE_C = 8'(STABLE);

  logic [NDIG-1:0]   an_q;
  logic [6:0]        seg_q;
  logic [7:0]        cnt_q, cnt_d;
  logic              state_q, state_d;
  logic [4*NDIG-1:0] shadow_code_q, shadow_code_d;
  logic [NDIG-1:0]   shadow_ok_q, shadow_ok_d;
  logic [NDIG-1:0]   captured_q, captured_d;
  logic [4*NDIG-1:0] digits_q, digits_d;
  logic [NDIG-1:0]   digit_ok_q, digit_ok_d;
  logic              frame_valid_q, frame_valid_d;
  logic              err_q, err_d;

  logic              pair_change;
  logic              an_blank;
  logic              an_single;
  logic              an_illegal;
  logic              commit;
  logic [IW-1:0]     idx;
  logic [3:0]        dec_code;
  logic              dec_ok;

  seg7_pattern_decode u_decode (
    .seg  (seg_q),
    .code (dec_code),
    .ok   (dec_ok)
  );

  // The pair about to be registered is compared with the held one, so cnt_q already
  // counts the edge at which the current pair was registered.
  assign pair_change = (an != an_q) || (seg != seg_q);
  assign an_blank    = &an_q;
  assign an_single   = $onehot(~an_q);
  assign an_illegal  = !an_blank && !an_single;

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (!an_q[i]) idx = IW'(i);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pair_change) begin
      cnt_d = 8'd1;
    end else if (cnt_q < STABLE_C) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Commit needs the pair to still be present on this edge, i.e. held STABLE cycles.
  assign commit = (state_q == ST_SETTLE) && an_single && !pair_change && (cnt_d == STABLE_C);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SETTLE: if (commit) state_d = ST_LOCKED;
      ST_LOCKED: state_d = ST_LOCKED;
      default:   state_d = ST_SETTLE;
    endcase
    // A new pair starts a new dwell; blank or illegal selects never hold a lock.
    if (pair_change || !an_single) state_d = ST_SETTLE;
  end

  always_comb begin
    shadow_code_d = shadow_code_q;
    shadow_ok_d   = shadow_ok_q;
    captured_d    = captured_q;
    digits_d      = digits_q;
    digit_ok_d    = digit_ok_q;
    frame_valid_d = 1'b0;
    err_d         = err_q | an_illegal;
    if (commit) begin
      shadow_code_d[{idx, 2'b00} +: 4] = dec_code;
      shadow_ok_d[idx]                 = dec_ok;
      captured_d[idx]                  = 1'b1;
      if (&captured_d) begin
        digits_d      = shadow_code_d;
        digit_ok_d    = shadow_ok_d;
        frame_valid_d = 1'b1;
        captured_d    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      cnt_q         <= '0;
      state_q       <= ST_SETTLE;
      shadow_code_q <= '0;
      shadow_ok_q   <= '0;
      captured_q    <= '0;
      digits_q      <= '1;
      digit_ok_q    <= '0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      an_q          <= an;
      seg_q         <= seg;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      shadow_code_q <= shadow_code_d;
      shadow_ok_q   <= shadow_ok_d;
      captured_q    <= captured_d;
      digits_q      <= digits_d;
      digit_ok_q    <= digit_ok_d;
      frame_valid_q <= frame_valid_d;
      err_q         <= err_d;
    end
  end

  assign digits      = digits_q;
  assign digit_ok    = digit_ok_q;
  assign frame_valid = frame_valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed bench for seg7_scan_decoder (NDIG = 8, STABLE = 4).
// Stimulus pushes the hand-computed frame it expects; a monitor pops it on frame_valid.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  ok;
  } frame_t;

  logic        clk;
  logic        rst;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic [31:0] digits;
  logic [7:0]  digit_ok;
  logic        frame_valid;
  logic        err;

  int          checks;
  int          errors;
  int          frames_seen;
  logic        fv_prev;
  frame_t      exp_q[$];
  logic [6:0]  seg_tab[10];

  seg7_scan_decoder #(
    .NDIG   (8),
    .STABLE (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .seg         (seg),
    .digits      (digits),
    .digit_ok    (digit_ok),
    .frame_valid (frame_valid),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sel(input int i);
    sel = ~(8'b1 << i);
  endfunction

  task automatic hold(input logic [7:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_digits"}, 64'(digits), 64'(32'hFFFF_FFFF));
    chk({tag, "_digit_ok"}, 64'(digit_ok), 64'(8'h00));
    chk({tag, "_frame_valid"}, 64'(frame_valid), 64'(1'b0));
    chk({tag, "_err"}, 64'(err), 64'(1'b0));
  endtask

  // Monitor: compare every published frame with the oldest expectation.
  always @(negedge clk) begin
    if (frame_valid) begin
      frames_seen++;
      if (fv_prev) chk("frame_valid_single_cycle", 64'(fv_prev), 64'(1'b0));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got digits %0h ok %0h, expected no frame",
                 digits, digit_ok);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        chk("frame_digits", 64'(digits), 64'(e.d));
        chk("frame_digit_ok", 64'(digit_ok), 64'(e.ok));
      end
    end
    fv_prev <= frame_valid;
  end

  initial begin
    checks      = 0;
    errors      = 0;
    frames_seen = 0;
    fv_prev     = 1'b0;
    seg_tab[0] = SEG_0; seg_tab[1] = SEG_1; seg_tab[2] = SEG_2; seg_tab[3] = SEG_3;
    seg_tab[4] = SEG_4; seg_tab[5] = SEG_5; seg_tab[6] = SEG_6; seg_tab[7] = SEG_7;
    seg_tab[8] = SEG_8; seg_tab[9] = SEG_9;
    clk = 1'b0;
    rst = 1'b1;
    an  = '1;
    seg = SEG_BLANK;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Plain scan: digit i shows i+1.
    exp_q.push_back('{d: 32'h8765_4321, ok: 8'hFF});
    for (int i = 0; i < 8; i++) hold(sel(i), seg_tab[i+1], 6);
    hold('1, SEG_BLANK, 3);
    chk("frames_after_scan", 64'(frames_seen), 64'(1));
    chk("err_after_scan", 64'(err), 64'(0));

    // Short dwell, exact-boundary dwell, bad pattern, blank pattern.
    exp_q.push_back('{d: 32'h96F4_3E10, ok: 8'hFB});
    hold(sel(0), SEG_0, 6);
    hold(sel(1), SEG_1, 6);
    hold(sel(2), 7'b1111110, 6);
    hold(sel(3), SEG_0, 3);
    hold(sel(4), SEG_4, 4);
    hold(sel(5), SEG_BLANK, 6);
    hold(sel(6), SEG_6, 6);
    hold(sel(7), SEG_9, 6);
    hold('1, SEG_BLANK, 3);
    chk("short_dwell_not_committed", 64'(frames_seen), 64'(1));
    hold(sel(3), SEG_3, 6);
    hold('1, SEG_BLANK, 3);
    chk("frames_after_patterns", 64'(frames_seen), 64'(2));

    // Illegal select mid-frame.
    exp_q.push_back('{d: 32'h9876_5432, ok: 8'hFF});
    for (int i = 0; i < 3; i++) hold(sel(i), seg_tab[i+2], 6);
    hold(8'b1110_0111, SEG_8, 10);
    chk("err_set_on_illegal", 64'(err), 64'(1));
    for (int i = 3; i < 8; i++) hold(sel(i), seg_tab[i+2], 6);
    hold('1, SEG_BLANK, 3);
    chk("err_sticky", 64'(err), 64'(1));
    chk("frames_after_illegal", 64'(frames_seen), 64'(3));

    // Long dwell on digit 0 with a one-cycle glitch: two commits of the held value.
    exp_q.push_back('{d: 32'h7654_3219, ok: 8'hFF});
    exp_q.push_back('{d: 32'h0000_0009, ok: 8'hFF});
    for (int i = 1; i < 8; i++) hold(sel(i), seg_tab[i], 6);
    hold(sel(0), SEG_9, 25);
    hold(sel(0), SEG_8, 1);
    hold(sel(0), SEG_9, 24);
    chk("frames_after_glitch_dwell", 64'(frames_seen), 64'(4));
    for (int i = 1; i < 8; i++) hold(sel(i), SEG_0, 6);
    hold('1, SEG_BLANK, 3);
    chk("frames_after_second_commit", 64'(frames_seen), 64'(5));

    // Partial frame discarded by a mid-operation reset.
    for (int i = 0; i < 7; i++) hold(sel(i), SEG_2, 6);
    rst = 1'b1;
    hold('1, SEG_BLANK, 2);
    chk_reset_outputs("mid_reset");
    rst = 1'b0;
    exp_q.push_back('{d: 32'h0123_4567, ok: 8'hFF});
    hold(sel(7), SEG_0, 6);
    chk("no_stale_capture", 64'(frames_seen), 64'(5));
    for (int i = 0; i < 7; i++) hold(sel(i), seg_tab[7-i], 6);
    hold('1, SEG_BLANK, 3);
    chk("frames_after_reset_scan", 64'(frames_seen), 64'(6));
    chk("expected_frames_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
